// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with byte-strobed writes, optional write-to-read
// bypass, optional hard-wired zero register and a per-entry busy scoreboard.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   raddr/rdata     NREAD combinational read ports, port k at slice k
//   rbusy           per-port busy flag of the addressed register
//   we/waddr/wdata  byte-strobed write port
//   wclr            clear busy[waddr] (writeback completes producer)
//   set_vld/set_addr mark busy[set_addr] (issue)
//   busy_any        OR of all registered busy bits
module regfile_mp_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREAD*ADDR_W-1:0]  raddr,
   output logic [NREAD*DATA_W-1:0]  rdata,
   output logic [NREAD-1:0]         rbusy,
   input  logic [DATA_W/8-1:0]      we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     wclr,
   input  logic                     set_vld,
   input  logic [ADDR_W-1:0]        set_addr,
   output logic                     busy_any
);

   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam bit          BYP    = (BYPASS != 0);
   localparam bit          ZR     = (ZERO_REG != 0);

   logic [DATA_W-1:0] rf_q [DEPTH];
   logic [DATA_W-1:0] rf_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              busy_any_q;
   logic              busy_any_d;
   logic              wr_ok_c;

   assign wr_ok_c = !(ZR && (waddr == '0));

   // Next-state for storage and scoreboard; set is applied after clear so it wins.
   always_comb begin
      rf_d   = rf_q;
      busy_d = busy_q;
      if (wr_ok_c) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (we[i]) rf_d[waddr][8*i +: 8] = wdata[8*i +: 8];
         end
      end
      if (wclr)    busy_d[waddr]    = 1'b0;
      if (set_vld) busy_d[set_addr] = 1'b1;
      if (ZR) begin
         rf_d[0]   = '0;
         busy_d[0] = 1'b0;
      end
      busy_any_d = |busy_d;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
         busy_q     <= '0;
         busy_any_q <= 1'b0;
      end else begin
         rf_q       <= rf_d;
         busy_q     <= busy_d;
         busy_any_q <= busy_any_d;
      end
   end

   assign busy_any = busy_any_q;

   // Independent combinational read ports with optional same-cycle forwarding.
   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              zero;
      logic              hit;
      logic [DATA_W-1:0] merged;

      assign ra   = raddr[k*ADDR_W +: ADDR_W];
      assign zero = ZR && (ra == '0);
      assign hit  = BYP && (waddr == ra) && !zero;

      // Strobed bytes come from wdata, the rest from the stored pre-write value.
      always_comb begin
         merged = rf_q[ra];
         if (hit) begin
            for (int i = 0; i < NBYTES; i++) begin
               if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
            end
         end
      end

      assign rdata[k*DATA_W +: DATA_W] = zero ? '0 : merged;
      // A same-cycle clear makes forwarded data final; a same-cycle set shows next cycle.
      assign rbusy[k] = !zero && busy_q[ra] && !(hit && wclr);
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

   logic        clk;
   logic        reset;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic [3:0]  we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        wclr;
   logic        set_vld;
   logic [4:0]  set_addr;
   logic        busy_any;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_rf [32];
   logic        m_busy [32];

   regfile_mp_sb dut (
      .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr), .set_vld(set_vld),
      .set_addr(set_addr), .busy_any(busy_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      reset = 1'b0; we = 4'h0; waddr = '0; wdata = '0;
      wclr = 1'b0; set_vld = 1'b0; set_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string n, input int p, input logic [4:0] a,
                       input logic [31:0] d, input logic b);
      e.name = n; e.port = p; e.data = d; e.busy = b;
      raddr[p*5 +: 5] = a;
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                         input logic [31:0] nw);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic test_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int a = 0; a < 32; a++) begin
         push("reset_read", 0, 5'(a), 32'h0, 1'b0);
         push("reset_read", 1, 5'(a), 32'h0, 1'b0);
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
               errors++;
               $display("FAIL %s port%0d addr%0d: got data=%h busy=%b expected data=%h busy=%b",
                        e.name, e.port, a, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
            end
         end
         checks++;
         if (busy_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_any: got %b expected 0", busy_any);
         end
         step();
      end
   endtask

   task automatic test_byte_write();
      idle();
      we = 4'hF; waddr = 5'd3; wdata = 32'h11223344;
      step();
      we = 4'b0101; waddr = 5'd3; wdata = 32'hAABBCCDD;
      push("byte_bypass", 0, 5'd3, 32'h11BB33DD, 1'b0);
      push("byte_bypass", 1, 5'd3, 32'h11BB33DD, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      step();
      idle();
      push("byte_stored", 0, 5'd3, 32'h11BB33DD, 1'b0);
      push("byte_other", 1, 5'd2, 32'h0, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      step();
   endtask

   task automatic test_zero_reg();
      idle();
      we = 4'hF; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_vld = 1'b1; set_addr = 5'd0;
      push("zero_same", 0, 5'd0, 32'h0, 1'b0);
      push("zero_same", 1, 5'd0, 32'h0, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      step();
      idle();
      push("zero_next", 0, 5'd0, 32'h0, 1'b0);
      push("zero_next", 1, 5'd0, 32'h0, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      checks++;
      if (busy_any !== 1'b0) begin
         errors++;
         $display("FAIL zero_busy_any: got %b expected 0", busy_any);
      end
      step();
   endtask

   task automatic test_scoreboard();
      idle();
      set_vld = 1'b1; set_addr = 5'd7;
      push("sb_set_not_visible", 1, 5'd7, 32'h0, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      step();
      idle();
      push("sb_busy", 1, 5'd7, 32'h0, 1'b1);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      checks++;
      if (busy_any !== 1'b1) begin
         errors++;
         $display("FAIL sb_busy_any_set: got %b expected 1", busy_any);
      end
      step();
      wclr = 1'b1; waddr = 5'd7; we = 4'hF; wdata = 32'd5;
      push("sb_clr_bypass", 1, 5'd7, 32'd5, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      checks++;
      if (busy_any !== 1'b1) begin
         errors++;
         $display("FAIL sb_busy_any_during_clr: got %b expected 1", busy_any);
      end
      step();
      idle();
      push("sb_after_clr", 1, 5'd7, 32'd5, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      checks++;
      if (busy_any !== 1'b0) begin
         errors++;
         $display("FAIL sb_busy_any_clear: got %b expected 0", busy_any);
      end
      step();
   endtask

   task automatic test_set_wins();
      idle();
      set_vld = 1'b1; set_addr = 5'd9;
      step();
      set_vld = 1'b1; set_addr = 5'd9; wclr = 1'b1; waddr = 5'd9;
      step();
      idle();
      push("set_wins", 0, 5'd9, 32'h0, 1'b1);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      step();
      set_vld = 1'b1; set_addr = 5'd10; wclr = 1'b1; waddr = 5'd9;
      step();
      idle();
      push("diff_clr", 0, 5'd9, 32'h0, 1'b0);
      push("diff_set", 1, 5'd10, 32'h0, 1'b1);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      step();
   endtask

   task automatic test_reset_collision();
      idle();
      reset = 1'b1; we = 4'hF; waddr = 5'd4; wdata = 32'd1; set_vld = 1'b1; set_addr = 5'd4;
      step();
      idle();
      for (int i = 0; i < 32; i++) begin
         m_rf[i] = '0;
         m_busy[i] = 1'b0;
      end
      push("rst_coll_r4", 0, 5'd4, 32'h0, 1'b0);
      push("rst_coll_r3", 1, 5'd3, 32'h0, 1'b0);
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
            errors++;
            $display("FAIL %s port%0d: got data=%h busy=%b expected data=%h busy=%b",
                     e.name, e.port, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
         end
      end
      checks++;
      if (busy_any !== 1'b0) begin
         errors++;
         $display("FAIL rst_coll_busy_any: got %b expected 0", busy_any);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [4:0]  r;
      logic [31:0] d1;
      idle();
      for (int n = 0; n < 40; n++) begin
         we    = 4'($urandom_range(0, 15));
         waddr = 5'($urandom_range(1, 31));
         wdata = $urandom;
         r     = 5'($urandom_range(0, 31));
         if (r == 5'd0)        d1 = 32'h0;
         else if (r == waddr)  d1 = merge(m_rf[r], we, wdata);
         else                  d1 = m_rf[r];
         push("b2b_fwd", 0, waddr, merge(m_rf[waddr], we, wdata), m_busy[waddr]);
         push("b2b_rand", 1, r, d1, m_busy[r]);
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rdata[e.port*32 +: 32] !== e.data || rbusy[e.port] !== e.busy) begin
               errors++;
               $display("FAIL %s port%0d iter%0d: got data=%h busy=%b expected data=%h busy=%b",
                        e.name, e.port, n, rdata[e.port*32 +: 32], rbusy[e.port], e.data, e.busy);
            end
         end
         m_rf[waddr] = merge(m_rf[waddr], we, wdata);
         step();
      end
      idle();
   endtask

   initial begin
      raddr = '0;
      idle();
      step();
      test_reset();
      test_byte_write();
      test_zero_reg();
      test_scoreboard();
      test_set_wins();
      test_reset_collision();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
